// File: rtl/comm_pkg.sv
// rtl/comm_pkg.sv - shared types and constants for the command arbiter
package comm_pkg;

    // Command word width carried from requesters to the transmitter.
    localparam int CMD_W = 16;

    // Default number of requesters sharing the transmitter.
    localparam int NUM_REQ_DEFAULT = 4;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_GUARD  = 2'd2,
        ST_WAIT   = 2'd3
    } arb_state_e;

endpackage : comm_pkg

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker
//
// Purpose: choose one requester from a request vector, searching cyclically
// upward starting at the priority pointer.
//
// Ports:
//   req_i  [N]        request vector
//   ptr_i  [clog2(N)] index with highest priority this round
//   gnt_o  [N]        one-hot grant (all zero when no request)
//   idx_o  [clog2(N)] binary index of the granted requester
//   any_o             at least one request present
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [N-1:0]         gnt_o,
    output logic [$clog2(N)-1:0] idx_o,
    output logic                 any_o
);

    localparam int IW = $clog2(N);

    always_comb begin
        int  j;
        logic found;
        j     = 0;
        found = 1'b0;
        gnt_o = '0;
        idx_o = '0;
        // Walk offsets 0..N-1 from the pointer; the first hit wins. The
        // pointer is always below N, so the modulo keeps j in range.
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr_i) + k) % N;
            if (!found && req_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IW'(j);
            end
        end
        any_o = found;
    end

endmodule : rr_pick

// File: rtl/cmd_arbiter.sv
// rtl/cmd_arbiter.sv - round-robin arbiter feeding one command transmitter
//
// Purpose: capture one command at a time from NUM_REQ requesters, launch it
// to the transmitter, wait for completion (or abandon it after TIMEOUT_CYC
// cycles of waiting) and rotate priority past the requester just served.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   req_vld      per-requester command pending
//   req_cmd      per-requester command, requester i at [16i+15:16i]
//   req_ack      one-cycle pulse when requester i's command is captured
//   req_done     one-cycle pulse when requester i's command completes
//   timeout      one-cycle pulse when the active command is abandoned
//   busy         high whenever the arbiter is not idle
//   owner        index of the captured requester
//   snd_cmd      one-cycle start strobe to the transmitter
//   cmd          captured command, stable until the next capture
//   cmd_cmplt    completion level from the transmitter
module cmd_arbiter
    import comm_pkg::*;
#(
    parameter int NUM_REQ     = NUM_REQ_DEFAULT,
    parameter int TIMEOUT_CYC = 65536
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_vld,
    input  logic [CMD_W*NUM_REQ-1:0]   req_cmd,
    output logic [NUM_REQ-1:0]         req_ack,
    output logic [NUM_REQ-1:0]         req_done,
    output logic                       timeout,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] owner,
    output logic                       snd_cmd,
    output logic [CMD_W-1:0]           cmd,
    input  logic                       cmd_cmplt
);

    localparam int IW = $clog2(NUM_REQ);
    // One spare value of headroom so the terminal count always fits.
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    arb_state_e           state_q, state_d;
    logic [IW-1:0]        ptr_q, ptr_d;
    logic [IW-1:0]        owner_q, owner_d;
    logic [CMD_W-1:0]     cmd_q, cmd_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 snd_q, snd_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic                 to_q, to_d;
    logic                 busy_q, busy_d;

    logic [NUM_REQ-1:0]   pick_gnt;
    logic [IW-1:0]        pick_idx;
    logic                 pick_any;
    logic [IW-1:0]        next_ptr;

    rr_pick #(
        .N(NUM_REQ)
    ) u_pick (
        .req_i (req_vld),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    // Priority moves to the requester after the one just finished.
    assign next_ptr = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cmd_d   = cmd_q;
        cnt_d   = cnt_q;
        snd_d   = 1'b0;
        ack_d   = '0;
        done_d  = '0;
        to_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    owner_d = pick_idx;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (pick_gnt[i]) begin
                            cmd_d = req_cmd[i*CMD_W +: CMD_W];
                        end
                    end
                    // Strobes are registered, so they are raised on entry
                    // and are visible for exactly the LAUNCH cycle.
                    snd_d   = 1'b1;
                    ack_d   = pick_gnt;
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                state_d = ST_GUARD;
            end
            ST_GUARD: begin
                // cmd_cmplt may still carry the previous command's level here.
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Completion is tested first so it beats a same-cycle timeout.
                if (cmd_cmplt) begin
                    done_d[owner_q] = 1'b1;
                    ptr_d           = next_ptr;
                    state_d         = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    to_d    = 1'b1;
                    ptr_d   = next_ptr;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            cmd_q   <= '0;
            cnt_q   <= '0;
            snd_q   <= 1'b0;
            ack_q   <= '0;
            done_q  <= '0;
            to_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cmd_q   <= cmd_d;
            cnt_q   <= cnt_d;
            snd_q   <= snd_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            to_q    <= to_d;
            busy_q  <= busy_d;
        end
    end

    assign req_ack  = ack_q;
    assign req_done = done_q;
    assign timeout  = to_q;
    assign busy     = busy_q;
    assign owner    = owner_q;
    assign snd_cmd  = snd_q;
    assign cmd      = cmd_q;

endmodule : cmd_arbiter

// File: tb/tb_cmd_arbiter.sv
// tb/tb_cmd_arbiter.sv - self-checking bench for cmd_arbiter
module tb_cmd_arbiter;

    localparam int NR = 4;
    localparam int TO = 64;

    logic          clk;
    logic          rst;
    logic [NR-1:0] req_vld;
    logic [16*NR-1:0] req_cmd;
    logic [NR-1:0] req_ack;
    logic [NR-1:0] req_done;
    logic          timeout;
    logic          busy;
    logic [1:0]    owner;
    logic          snd_cmd;
    logic [15:0]   cmd;
    logic          cmd_cmplt;

    int errors = 0;
    int checks = 0;
    int m_ptr  = 0;

    cmd_arbiter #(
        .NUM_REQ     (NR),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_vld   (req_vld),
        .req_cmd   (req_cmd),
        .req_ack   (req_ack),
        .req_done  (req_done),
        .timeout   (timeout),
        .busy      (busy),
        .owner     (owner),
        .snd_cmd   (snd_cmd),
        .cmd       (cmd),
        .cmd_cmplt (cmd_cmplt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Winner is the pending requester at the smallest cyclic distance
    // forward from the priority pointer.
    function automatic int model_winner(input logic [NR-1:0] vld, input int ptr);
        int best;
        int best_dist;
        best      = -1;
        best_dist = NR;
        for (int j = 0; j < NR; j++) begin
            if (vld[j]) begin
                int d;
                d = (j - ptr + NR) % NR;
                if (d < best_dist) begin
                    best_dist = d;
                    best      = j;
                end
            end
        end
        return best;
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_snd"}, 32'(snd_cmd), 32'd0);
        chk({tag, "_ack"}, 32'(req_ack), 32'd0);
        chk({tag, "_done"}, 32'(req_done), 32'd0);
        chk({tag, "_timeout"}, 32'(timeout), 32'd0);
        chk({tag, "_owner"}, 32'(owner), 32'd0);
        chk({tag, "_cmd"}, 32'(cmd), 32'd0);
    endtask

    // One full command. Called during an IDLE-bound cycle; returns in the
    // cycle showing the done/timeout pulse with req_vld and cmd_cmplt low.
    // lat = WAIT cycle index at which cmd_cmplt rises (>= TO means never).
    task automatic txn(input logic [NR-1:0] vld, input logic [16*NR-1:0] cmds,
                       input int lat, input bit stale, output int w);
        logic [15:0] exp_cmd;
        bit          fin;
        w         = model_winner(vld, m_ptr);
        exp_cmd   = cmds[w*16 +: 16];
        req_vld   = vld;
        req_cmd   = cmds;
        cmd_cmplt = stale;
        step();
        chk("launch_snd", 32'(snd_cmd), 32'd1);
        chk("launch_ack", 32'(req_ack), 32'(1 << w));
        chk("launch_owner", 32'(owner), 32'(w));
        chk("launch_cmd", 32'(cmd), 32'(exp_cmd));
        chk("launch_busy", 32'(busy), 32'd1);
        chk("launch_no_end", {30'd0, |req_done, timeout}, 32'd0);
        // Requests changing after capture must not disturb the active command.
        req_vld = NR'($urandom);
        req_cmd = {$urandom, $urandom};
        step();
        chk("guard_strobes", {30'd0, snd_cmd, |req_ack}, 32'd0);
        chk("guard_owner", 32'(owner), 32'(w));
        step();
        chk("wait0_state", {29'd0, busy, |req_done, timeout}, 32'd4);
        fin = 1'b0;
        for (int c = 0; c < TO && !fin; c++) begin
            cmd_cmplt = (c == lat);
            step();
            if (c == lat) begin
                chk("done_pulse", 32'(req_done), 32'(1 << w));
                chk("done_no_timeout", 32'(timeout), 32'd0);
                chk("done_busy", 32'(busy), 32'd0);
                fin = 1'b1;
            end else if (c == TO - 1) begin
                chk("timeout_pulse", 32'(timeout), 32'd1);
                chk("timeout_no_done", 32'(req_done), 32'd0);
                chk("timeout_busy", 32'(busy), 32'd0);
                fin = 1'b1;
            end else begin
                chk("wait_state", {29'd0, busy, |req_done, timeout}, 32'd4);
            end
        end
        chk("end_cmd_held", 32'(cmd), 32'(exp_cmd));
        chk("end_no_launch", 32'(snd_cmd), 32'd0);
        m_ptr     = (w + 1) % NR;
        cmd_cmplt = 1'b0;
        req_vld   = '0;
    endtask

    initial begin
        int w;
        int r;
        int lat;
        rst       = 1'b1;
        req_vld   = '0;
        req_cmd   = '0;
        cmd_cmplt = 1'b0;
        step();
        step();
        chk_reset_outputs("reset");
        rst = 1'b0;
        step();
        step();
        chk_reset_outputs("idle_no_req");

        // Withdrawn request: raised and dropped before any edge samples it.
        req_vld = 4'b0010;
        #2;
        req_vld = 4'b0000;
        step();
        chk("withdraw_busy", {30'd0, busy, snd_cmd}, 32'd0);

        // Fairness from reset: all four pending.
        for (int k = 0; k < 4; k++) begin
            txn(4'b1111, {$urandom, $urandom}, 2, 1'b0, w);
            chk("fair_all", 32'(w), 32'(k));
        end
        txn(4'b0101, {$urandom, $urandom}, 1, 1'b0, w);
        chk("fair_02_first", 32'(w), 32'd0);
        txn(4'b0101, {$urandom, $urandom}, 1, 1'b0, w);
        chk("fair_02_second", 32'(w), 32'd2);

        // Single request with a fixed command, completion 30 cycles after launch.
        txn(4'b0001, {48'h1234_5678_9ABC, 16'hA55A}, 28, 1'b0, w);
        chk("single_owner", 32'(w), 32'd0);
        step();
        chk("single_done_once", 32'(req_done), 32'd0);

        // Timeout, then the next request is still served.
        txn(4'b0010, {$urandom, $urandom}, 1000, 1'b0, w);
        txn(4'b1111, {$urandom, $urandom}, 3, 1'b0, w);
        chk("after_timeout_owner", 32'(w), 32'd2);

        // Completion on the terminal count wins over timeout.
        txn(4'b0100, {$urandom, $urandom}, TO - 1, 1'b0, w);
        // One short of the terminal count completes normally as well.
        txn(4'b1000, {$urandom, $urandom}, TO - 2, 1'b0, w);

        // Stale completion level held through launch and guard.
        txn(4'b0001, {$urandom, $urandom}, 5, 1'b1, w);

        // Reset in the middle of WAIT, with completion asserted at that edge.
        req_vld = 4'b0100;
        req_cmd = {$urandom, $urandom};
        step();
        chk("rstmid_owner", 32'(owner), 32'd2);
        req_vld = '0;
        step();
        step();
        step();
        step();
        rst       = 1'b1;
        cmd_cmplt = 1'b1;
        step();
        chk_reset_outputs("rst_mid_wait");
        rst       = 1'b0;
        cmd_cmplt = 1'b0;
        m_ptr     = 0;
        step();
        chk("post_rst_idle", {29'd0, busy, |req_done, timeout}, 32'd0);
        txn(4'b1111, {$urandom, $urandom}, 0, 1'b0, w);
        chk("post_rst_ptr0", 32'(w), 32'd0);

        // Randomized commands against the model.
        for (int n = 0; n < 40; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 6)       lat = int'($urandom_range(0, 12));
            else if (r < 8)  lat = TO - 1;
            else if (r == 8) lat = TO - 2;
            else             lat = 500;
            txn(NR'($urandom_range(1, 15)), {$urandom, $urandom}, lat,
                1'($urandom_range(0, 1)), w);
            if ($urandom_range(0, 1) == 1) begin
                step();
                chk("rand_gap_idle", {29'd0, busy, |req_done, timeout}, 32'd0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_cmd_arbiter

// File: doc/cmd_arbiter.md
CMD_ARBITER -- requirements
Module: cmd_arbiter

Interface
REQ-001 Clocking: one clock; reset is synchronous and active-high.
REQ-002 Parameter NUM_REQ, default 4: number of requesters (2..8).
REQ-003 Parameter TIMEOUT_CYC, default 65536: maximum cycles in WAIT before the command is abandoned.
REQ-004 Port clk, input, 1: system clock, rising edge.
REQ-005 Port rst, input, 1: synchronous active-high reset.
REQ-006 Port req_vld, input, NUM_REQ: requester i has a command pending.
REQ-007 Port req_cmd, input, 16*NUM_REQ: requester i command at bits [16i+15:16i].
REQ-008 Port req_ack, output, NUM_REQ: one-cycle pulse when requester i's command is captured.
REQ-009 Port req_done, output, NUM_REQ: one-cycle pulse when requester i's command completes.
REQ-010 Port timeout, output, 1: one-cycle pulse when the active command times out.
REQ-011 Port busy, output, 1: high in every state except IDLE.
REQ-012 Port owner, output, $clog2(NUM_REQ): index of the captured requester, valid while busy.
REQ-013 Port snd_cmd, output, 1: one-cycle start strobe to the command transmitter.
REQ-014 Port cmd, output, 16: captured command to the transmitter, held stable from LAUNCH until the next capture.
REQ-015 Port cmd_cmplt, input, 1: transmitter completion level; cleared by the transmitter one cycle after snd_cmd.

Function
REQ-016 The FSM SHALL have states IDLE, LAUNCH, GUARD and WAIT.
REQ-017 IDLE, any req_vld high: pick winner w by round-robin starting at ptr, register cmd<=req_cmd[w] and owner<=w, go to LAUNCH.
REQ-018 IDLE, no req_vld: remain in IDLE with all strobes low.
REQ-019 LAUNCH: snd_cmd=1 and req_ack[owner]=1 for exactly this cycle, then go to GUARD.
REQ-020 GUARD: cmd_cmplt is ignored for one cycle (stale level from the previous command), then go to WAIT with the counter cleared.
REQ-021 WAIT, cmd_cmplt=1: req_done[owner]=1 for one cycle, ptr<=(owner+1) mod NUM_REQ, go to IDLE.
REQ-022 WAIT, cmd_cmplt=0: increment counter; when counter reaches TIMEOUT_CYC-1, pulse timeout, ptr<=(owner+1) mod NUM_REQ, go to IDLE, no req_done.
REQ-023 cmd_cmplt and timeout in the same cycle: completion wins, no timeout pulse.
REQ-024 Latency: req_vld high in IDLE gives req_ack and snd_cmd on the next cycle.
REQ-025 Back-to-back: at least one IDLE cycle between req_done/timeout and the next LAUNCH.
REQ-026 req_vld dropped before capture withdraws the request; req_vld/req_cmd changes after capture do not affect the active command.
REQ-027 Round-robin: a continuously requesting requester SHALL be served within NUM_REQ commands.
REQ-028 The counter SHALL be wide enough for TIMEOUT_CYC without wrap; ptr wraps from NUM_REQ-1 to 0.
REQ-029 All outputs SHALL be registered (glitch-free).

Reset
REQ-030 Reset SHALL set state=IDLE, ptr=0, owner=0, cmd=16'h0000 and counter=0.
REQ-031 Reset SHALL drive snd_cmd, req_ack, req_done, timeout and busy low.
REQ-032 Reset in any state abandons the command with no req_done or timeout pulse; outputs are at reset values in the cycle after rst is sampled high.

Structure
REQ-033 Shared package comm_pkg SHALL hold the FSM state enum, CMD_W=16 and the default NUM_REQ.
REQ-034 Sub-module rr_pick (combinational: req vector + ptr -> one-hot grant and index) SHALL implement REQ-017/REQ-027.

Verification
REQ-035 Single request: req_vld[0]=1 with cmd 16'hA55A -> next cycle snd_cmd=1, req_ack[0]=1, cmd=A55A; cmd_cmplt 30 cycles later -> req_done[0] pulse, busy low the following cycle.
REQ-036 Fairness: all four req_vld high from reset -> grant order 0,1,2,3; then only req 0 and 2 high -> order 0,2.
REQ-037 Timeout: TIMEOUT_CYC=64, cmd_cmplt held low -> timeout pulses 64 cycles after WAIT entry, no req_done, next request served.
REQ-038 Stale completion: cmd_cmplt held high until one cycle after snd_cmd -> no early req_done; a later rise completes normally.
REQ-039 Reset mid-WAIT: rst=1 for one cycle -> the next cycle has all outputs at reset values, no req_done/timeout, ptr=0.
REQ-040 Simultaneous completion and timeout in cycle 63 with TIMEOUT_CYC=64 -> req_done only.
